// File: rtl/soc_sim_monitor.sv
// soc_sim_monitor: run-control and test-completion monitor.
// Holds the SoC in reset for RST_CYCLES after board reset release, counts run
// cycles, and latches a sticky verdict on the first of: mailbox exit write,
// filtered trap, or timeout.
module soc_sim_monitor #(
  parameter int unsigned RST_CYCLES     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned TRAP_FILTER    = 1,
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             trap_i,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic             soc_resetn,
  output logic             done,
  output logic             pass,
  output logic [1:0]       cause,
  output logic [30:0]      exit_code,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

  localparam logic [1:0] C_MBOX = 2'd1;
  localparam logic [1:0] C_TRAP = 2'd2;
  localparam logic [1:0] C_TMO  = 2'd3;

  // Hold counter counts resetn-high edges; the release happens on the edge
  // after it has seen RST_CYCLES of them.
  localparam logic [15:0]      RST_LAST  = 16'(RST_CYCLES);
  localparam logic [3:0]       TRAP_LAST = 4'(TRAP_FILTER - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] hold_cnt;
  logic [3:0]  trap_cnt;

  logic        hit, is_rd, mb_end, trap_hit, tmo_hit;
  logic [31:0] rd_word;

  // Byte offset bits inside a word are irrelevant to this decode.
  wire unused_addr = &{1'b0, mem_addr[1:0]};

  // Mailbox decode; a request seen while mem_ready is high is the previous
  // transfer still held by the master, so it is not accepted again.
  always_comb begin
    hit      = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]) &&
               !mem_ready && (state != HOLD);
    is_rd    = (mem_wstrb == 4'h0);
    rd_word  = mem_addr[2] ? 32'(cycle_count) : {exit_code, done};
    mb_end   = (state == RUN) && hit && !mem_addr[2] &&
               (mem_wstrb == 4'hF) && mem_wdata[0];
    trap_hit = (state == RUN) && trap_i && (trap_cnt == TRAP_LAST);
    tmo_hit  = (TIMEOUT_CYCLES != 0) && (state == RUN) &&
               (cycle_count == TMO_LAST);
  end

  // Run-control FSM, bus responder and verdict latch, all registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      trap_cnt    <= '0;
      cycle_count <= '0;
      soc_resetn  <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      cause       <= '0;
      exit_code   <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
    end else begin
      mem_ready <= hit;
      mem_rdata <= (hit && is_rd) ? rd_word : 32'h0;
      case (state)
        HOLD: begin
          if (hold_cnt == RST_LAST) begin
            state      <= RUN;
            soc_resetn <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!trap_i)               trap_cnt <= '0;
          else if (trap_cnt != 4'hF) trap_cnt <= trap_cnt + 4'd1;
          if (mb_end || trap_hit || tmo_hit) begin
            // Count freezes on the event edge so a timeout reads TIMEOUT-1.
            state <= DONE;
            done  <= 1'b1;
            if (mb_end) begin
              cause     <= C_MBOX;
              exit_code <= mem_wdata[31:1];
              pass      <= (mem_wdata[31:1] == 31'd0);
            end else if (trap_hit) begin
              cause <= C_TRAP;
            end else begin
              cause <= C_TMO;
            end
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        DONE: ;
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_sim_monitor.sv
// Directed bench for soc_sim_monitor: a vector table for reset release and
// mailbox protocol, plus sequences for traps, event priority and timeout.
module tb_soc_sim_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: TRAP_FILTER=3, timeout disabled.
  logic        resetn, trap_i, mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, soc_resetn, done, pass;
  logic [31:0] mem_rdata, cycle_count;
  logic [1:0]  cause;
  logic [30:0] exit_code;

  // Instance 2: short hold, TIMEOUT_CYCLES=50, bus and trap idle.
  logic        resetn2, trap_i2, mem_valid2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [3:0]  mem_wstrb2;
  logic        mem_ready2, soc_resetn2, done2, pass2;
  logic [31:0] mem_rdata2, cycle_count2;
  logic [1:0]  cause2;
  logic [30:0] exit_code2;

  soc_sim_monitor #(.RST_CYCLES(10), .TIMEOUT_CYCLES(0), .TRAP_FILTER(3),
                    .CNT_W(32), .BASE_ADDR(32'h1000_0000)) dut (
    .clk(clk), .resetn(resetn), .trap_i(trap_i), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .soc_resetn(soc_resetn),
    .done(done), .pass(pass), .cause(cause), .exit_code(exit_code),
    .cycle_count(cycle_count));

  soc_sim_monitor #(.RST_CYCLES(4), .TIMEOUT_CYCLES(50), .TRAP_FILTER(1),
                    .CNT_W(32), .BASE_ADDR(32'h1000_0000)) dut2 (
    .clk(clk), .resetn(resetn2), .trap_i(trap_i2), .mem_valid(mem_valid2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wstrb(mem_wstrb2),
    .mem_ready(mem_ready2), .mem_rdata(mem_rdata2), .soc_resetn(soc_resetn2),
    .done(done2), .pass(pass2), .cause(cause2), .exit_code(exit_code2),
    .cycle_count(cycle_count2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstn, trap, valid;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        e_soc, e_rdy;
    logic [31:0] e_rdata;
    logic        e_done, e_pass;
    logic [1:0]  e_cause;
    logic [30:0] e_exit;
    int          e_cnt;   // -1: not compared
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rstn, logic trap, logic valid,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] wstrb, logic e_soc, logic e_rdy,
                              logic [31:0] e_rdata, logic e_done,
                              logic e_pass, logic [1:0] e_cause,
                              logic [30:0] e_exit, int e_cnt);
    vec_t v;
    v.rstn = rstn; v.trap = trap; v.valid = valid; v.addr = addr;
    v.wdata = wdata; v.wstrb = wstrb; v.e_soc = e_soc; v.e_rdy = e_rdy;
    v.e_rdata = e_rdata; v.e_done = e_done; v.e_pass = e_pass;
    v.e_cause = e_cause; v.e_exit = e_exit; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trap_i = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0;
    mem_wdata = 32'h0; mem_wstrb = 4'h0;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
  endtask

  task automatic verdict(input string tag, input logic d, input logic p,
                         input logic [1:0] c, input logic [30:0] e);
    chk({tag, "_done"}, done, d);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_cause"}, cause, c);
    chk({tag, "_exit"}, exit_code, e);
  endtask

  // Release resetn and check soc_resetn over the 10-edge hold window.
  task automatic hold_release();
    idle();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold%0d_soc", i), soc_resetn, 1'b0);
    end
    tick();
    chk("run_soc", soc_resetn, 1'b1);
    chk("run_cnt0", cycle_count, 32'd0);
  endtask

  task automatic hold_seq();
    idle();
    resetn = 1'b0;
    tick();
    chk("rst_soc", soc_resetn, 1'b0);
    verdict("rst", 1'b0, 1'b0, 2'd0, 31'd0);
    hold_release();
  endtask

  localparam logic [31:0] MB0 = 32'h1000_0000;
  localparam logic [31:0] MB4 = 32'h1000_0004;
  localparam logic [31:0] MBX = 32'h1000_0010;

  initial begin
    resetn = 1'b0; resetn2 = 1'b0;
    idle();
    trap_i2 = 1'b0; mem_valid2 = 1'b0; mem_addr2 = 32'h0;
    mem_wdata2 = 32'h0; mem_wstrb2 = 4'h0;

    // rstn trap valid addr wdata strb | soc rdy rdata done pass cause exit cnt
    tbl.push_back(mk(0,0,0,0,0,0,       0,0,0,0,0,0,0,0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1,0,0,0,0,0,     0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,MB4,0,0,     1,1,0,0,0,0,0,1));    // read count
    tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,0,0,0,0,2));
    tbl.push_back(mk(1,1,0,0,0,0,       1,0,0,0,0,0,0,3));    // lone trap
    tbl.push_back(mk(1,0,1,MB0,1,4'h3,  1,1,0,0,0,0,0,4));    // partial strobe
    tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,0,0,0,0,5));
    tbl.push_back(mk(1,0,1,MB0,2,4'hF,  1,1,0,0,0,0,0,6));    // bit0 clear
    tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,0,0,0,0,7));
    tbl.push_back(mk(1,0,1,MB4,1,4'hF,  1,1,0,0,0,0,0,8));    // offset 4 write
    tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,0,0,0,0,9));
    tbl.push_back(mk(1,0,1,MB4,0,0,     1,1,9,0,0,0,0,10));
    tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,0,0,0,0,11));
    tbl.push_back(mk(1,0,1,MB0,1,4'hF,  1,1,0,1,1,1,0,-1));   // pass exit
    tbl.push_back(mk(1,0,1,MB0,1,4'hF,  1,0,0,1,1,1,0,-1));   // held, no re-ack
    tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,1,1,1,0,-1));
    tbl.push_back(mk(1,0,1,MB0,0,0,     1,1,1,1,1,1,0,-1));   // read status
    tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,1,1,1,0,-1));
    tbl.push_back(mk(1,0,1,MBX,0,0,     1,0,0,1,1,1,0,-1));   // miss
    tbl.push_back(mk(1,0,1,MBX,0,0,     1,0,0,1,1,1,0,-1));
    tbl.push_back(mk(1,0,1,MB0,7,4'hF,  1,1,0,1,1,1,0,-1));   // write in DONE
    tbl.push_back(mk(1,1,0,0,0,0,       1,0,0,1,1,1,0,-1));
    tbl.push_back(mk(1,1,0,0,0,0,       1,0,0,1,1,1,0,-1));
    tbl.push_back(mk(1,1,0,0,0,0,       1,0,0,1,1,1,0,-1));   // trap ignored
    tbl.push_back(mk(1,0,1,MB0,0,0,     1,1,1,1,1,1,0,-1));
    tbl.push_back(mk(0,0,1,MB0,0,0,     0,0,0,0,0,0,0,0));    // reset in DONE

    for (int i = 0; i < tbl.size(); i++) begin
      resetn = tbl[i].rstn; trap_i = tbl[i].trap; mem_valid = tbl[i].valid;
      mem_addr = tbl[i].addr; mem_wdata = tbl[i].wdata;
      mem_wstrb = tbl[i].wstrb;
      tick();
      chk($sformatf("row%0d_soc", i), soc_resetn, tbl[i].e_soc);
      chk($sformatf("row%0d_rdy", i), mem_ready, tbl[i].e_rdy);
      chk($sformatf("row%0d_rdata", i), mem_rdata, tbl[i].e_rdata);
      verdict($sformatf("row%0d", i), tbl[i].e_done, tbl[i].e_pass,
              tbl[i].e_cause, tbl[i].e_exit);
      if (tbl[i].e_cnt >= 0)
        chk($sformatf("row%0d_cnt", i), cycle_count, tbl[i].e_cnt);
    end

    // Hold sequence restarts after the one-cycle reset pulse; fail exit 3.
    hold_release();
    bus(MB0, 32'h0000_0007, 4'hF);
    tick();
    chk("fail_rdy", mem_ready, 1'b1);
    verdict("fail", 1'b1, 1'b0, 2'd1, 31'd3);
    idle();
    tick();
    bus(MB0, 32'h0, 4'h0);
    tick();
    chk("fail_rd", mem_rdata, 32'h0000_0007);
    idle();

    // Trap filter: a 2-cycle burst is rejected, a 3-cycle burst ends the run.
    hold_seq();
    trap_i = 1'b1;
    tick(); chk("trapA1_done", done, 1'b0);
    tick(); chk("trapA2_done", done, 1'b0);
    trap_i = 1'b0;
    tick(); chk("trapgap_done", done, 1'b0);
    trap_i = 1'b1;
    tick(); chk("trapB1_done", done, 1'b0);
    tick(); chk("trapB2_done", done, 1'b0);
    tick(); verdict("trapB3", 1'b1, 1'b0, 2'd2, 31'd0);
    idle();

    // Mailbox pass and trap completion on the same edge: mailbox wins.
    hold_seq();
    trap_i = 1'b1;
    tick(); tick();
    bus(MB0, 32'h0000_0001, 4'hF);
    tick();
    chk("prio_rdy", mem_ready, 1'b1);
    verdict("prio", 1'b1, 1'b1, 2'd1, 31'd0);
    mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    verdict("prio_late", 1'b1, 1'b1, 2'd1, 31'd0);
    idle();

    // Timeout disabled: a long idle run never finishes.
    hold_seq();
    for (int i = 0; i < 3000; i++) tick();
    verdict("notmo", 1'b0, 1'b0, 2'd0, 31'd0);
    chk("notmo_cnt", cycle_count, 32'd3000);

    // Timeout on instance 2 (RST_CYCLES=4, TIMEOUT_CYCLES=50).
    resetn2 = 1'b0;
    tick();
    chk("t2_rst_soc", soc_resetn2, 1'b0);
    resetn2 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_hold_soc", soc_resetn2, 1'b0);
    tick();
    chk("t2_run_soc", soc_resetn2, 1'b1);
    chk("t2_run_cnt", cycle_count2, 32'd0);
    for (int i = 0; i < 49; i++) tick();
    chk("t2_pre_cnt", cycle_count2, 32'd49);
    chk("t2_pre_done", done2, 1'b0);
    tick();
    chk("t2_done", done2, 1'b1);
    chk("t2_cause", cause2, 2'd3);
    chk("t2_pass", pass2, 1'b0);
    chk("t2_cnt", cycle_count2, 32'd49);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_frz_cnt", cycle_count2, 32'd49);
    chk("t2_frz_done", done2, 1'b1);
    chk("t2_frz_cause", cause2, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
